// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch initiator. Owns the program counter, drives the
// instruction memory address combinationally, captures the returned word on
// the next rising edge and presents it to decode through a valid/ready
// handshake. Execute can redirect the PC, which flushes any fetched but
// unconsumed instruction. Delivered instructions are counted.
//
// Ports:
//   clock            - system clock, rising edge
//   reset            - asynchronous, active-high reset
//   enable           - fetch enable; low stops new fetches
//   imem_address     - instruction memory byte address (always equals pc)
//   imem_instruction - word returned combinationally for imem_address
//   instr_valid      - instr/instr_pc hold a valid instruction
//   instr_ready      - decode accepts the instruction this cycle
//   instr            - fetched instruction word
//   instr_pc         - address the instruction was fetched from
//   redirect_valid   - load a new pc this cycle
//   redirect_target  - new pc for a redirect (low two bits are dropped)
//   fetch_count      - number of handshakes completed (wraps)
//   misaligned_error - sticky flag: a redirect target was not word aligned
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_count,
  output logic        misaligned_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    STALL    = 2'b10,
    RESERVED = 2'b11
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic        transfer;
  logic        fetch;
  logic        state_legal;

  // The handshake completes when decode sees a valid word and accepts it.
  // A fetch needs an empty output slot, or one being emptied on this edge,
  // and never happens on a redirect edge so the new target is read next.
  // The reserved encoding is excluded so a corrupted state cannot load a
  // word that would then be discarded while the pc still advances.
  always_comb begin
    state_legal  = (state != RESERVED);
    transfer     = instr_valid && instr_ready;
    fetch        = enable && !redirect_valid && state_legal &&
                   (!instr_valid || transfer);
    imem_address = pc;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Redirect wins over everything; an occupied output
  // slot either refills (RUN), drains to IDLE when no fetch follows the
  // transfer, or waits in STALL until decode accepts it.
  always_comb begin
    next_state = IDLE;
    if (redirect_valid) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: next_state = fetch ? RUN : IDLE;
        RUN, STALL: begin
          if (transfer) begin
            next_state = fetch ? RUN : IDLE;
          end else begin
            next_state = STALL;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output logic: the output slot is valid exactly in RUN and STALL, so the
  // reserved encoding reads as empty.
  always_comb begin
    instr_valid = (state == RUN) || (state == STALL);
  end

  // Program counter. A redirect loads the word-aligned target; otherwise
  // the pc steps by one word on every fetch and wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_target[31:2], 2'b00};
    end else if (fetch) begin
      pc <= pc + 32'd4;
    end
  end

  // Captured instruction and its address. Only a fetch changes them, so
  // they are stable while the slot stalls; a flush just clears the valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr    <= 32'h0;
      instr_pc <= 32'h0;
    end else if (fetch) begin
      instr    <= imem_instruction;
      instr_pc <= pc;
    end
  end

  // Delivered-instruction counter. A transfer on a redirect edge still
  // counts because decode really took the word; a flushed word never
  // completes a handshake and so is never counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (transfer) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      misaligned_error <= 1'b0;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      misaligned_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. The memory model returns 0xA000_0000 | address.
// A second instance with RESET_PC = 0xFFFF_FFFC shares the inputs and covers
// the pc wrap.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;
  logic        misaligned_error;

  logic [31:0] wrap_imem_address;
  logic [31:0] wrap_imem_instruction;
  logic        wrap_instr_valid;
  logic [31:0] wrap_instr;
  logic [31:0] wrap_instr_pc;
  logic [31:0] wrap_fetch_count;
  logic        wrap_misaligned_error;

  int assertCount;
  int failCount;

  // Combinational instruction memory models for both instances.
  assign imem_instruction      = 32'hA000_0000 | imem_address;
  assign wrap_imem_instruction = 32'hA000_0000 | wrap_imem_address;

  fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .fetch_count      (fetch_count),
    .misaligned_error (misaligned_error)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) wrap_dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .imem_address     (wrap_imem_address),
    .imem_instruction (wrap_imem_instruction),
    .instr_valid      (wrap_instr_valid),
    .instr_ready      (instr_ready),
    .instr            (wrap_instr),
    .instr_pc         (wrap_instr_pc),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .fetch_count      (wrap_fetch_count),
    .misaligned_error (wrap_misaligned_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy,
                               input logic redir, input logic [31:0] target);
    enable          = en;
    instr_ready     = rdy;
    redirect_valid  = redir;
    redirect_target = target;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #12;

    // Reset state
    checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_addr", imem_address, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    checkOutput("rst_count", fetch_count, 32'h0);
    checkOutput("rst_misaligned", {31'h0, misaligned_error}, 32'h0);
    checkOutput("rst_wrap_addr", wrap_imem_address, 32'hFFFF_FFFC);

    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Streaming, one instruction per cycle
    tick;
    checkOutput("s0_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("s0_instr", instr, 32'hA000_0000);
    checkOutput("s0_pc", instr_pc, 32'h0);
    checkOutput("s0_addr", imem_address, 32'h4);
    checkOutput("wrap0_pc", wrap_instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap0_addr", wrap_imem_address, 32'h0);
    tick;
    checkOutput("s1_instr", instr, 32'hA000_0004);
    checkOutput("s1_pc", instr_pc, 32'h4);
    checkOutput("s1_count", fetch_count, 32'h1);
    checkOutput("wrap1_pc", wrap_instr_pc, 32'h0);
    checkOutput("wrap1_instr", wrap_instr, 32'hA000_0000);
    tick;
    checkOutput("s2_instr", instr, 32'hA000_0008);
    checkOutput("s2_pc", instr_pc, 32'h8);
    checkOutput("s2_count", fetch_count, 32'h2);

    // Stall three cycles on instr_pc 8
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("stall_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("stall_instr", instr, 32'hA000_0008);
      checkOutput("stall_addr", imem_address, 32'hC);
      checkOutput("stall_count", fetch_count, 32'h2);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("unstall_pc", instr_pc, 32'hC);
    checkOutput("unstall_count", fetch_count, 32'h3);
    tick;
    checkOutput("s4_pc", instr_pc, 32'h10);
    checkOutput("s4_count", fetch_count, 32'h4);

    // Stall on 0x10, then redirect to 0x40
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("st10_pc", instr_pc, 32'h10);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    tick;
    checkOutput("redir_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("redir_addr", imem_address, 32'h40);
    checkOutput("redir_count", fetch_count, 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("r40_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("r40_instr", instr, 32'hA000_0040);
    checkOutput("r40_pc", instr_pc, 32'h40);
    checkOutput("r40_count", fetch_count, 32'h4);
    checkOutput("r40_misaligned", {31'h0, misaligned_error}, 32'h0);

    // Redirect to misaligned 0x22 in the same cycle as a transfer
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h22);
    tick;
    checkOutput("rx_count", fetch_count, 32'h5);
    checkOutput("rx_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rx_addr", imem_address, 32'h20);
    checkOutput("rx_misaligned", {31'h0, misaligned_error}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("r20_pc", instr_pc, 32'h20);
    checkOutput("r20_instr", instr, 32'hA000_0020);
    checkOutput("r20_count", fetch_count, 32'h5);
    tick;
    checkOutput("r24_pc", instr_pc, 32'h24);
    checkOutput("r24_count", fetch_count, 32'h6);
    checkOutput("sticky_misaligned", {31'h0, misaligned_error}, 32'h1);

    // enable dropped while stalled: instruction held, then drained to IDLE
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("en0_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("en0_pc", instr_pc, 32'h24);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("drain_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("drain_count", fetch_count, 32'h7);
    checkOutput("drain_addr", imem_address, 32'h28);
    tick;
    checkOutput("idle_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("idle_misaligned", {31'h0, misaligned_error}, 32'h1);

    // Asynchronous reset mid-stall
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("pre_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("pre_pc", instr_pc, 32'h28);
    tick;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("async_addr", imem_address, 32'h0);
    checkOutput("async_count", fetch_count, 32'h0);
    checkOutput("async_misaligned", {31'h0, misaligned_error}, 32'h0);
    checkOutput("async_instr_pc", instr_pc, 32'h0);
    checkOutput("async_wrap_addr", wrap_imem_address, 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the instruction memory's address port and captures the returned 32-bit word.
- Owns the program counter (PC) and presents fetched instructions to decode through a valid/ready handshake.
- Accepts redirects (jumps/taken branches) from execute, flushes the fetched-but-unconsumed instruction, and counts delivered instructions.
- The instruction memory is combinational read, byte-addressed, one word per 4-byte-aligned address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  fetch enable; low = no new fetches
- imem_address  output  32  instruction memory address (= PC, combinational)
- imem_instruction  input  32  instruction word returned combinationally for imem_address
- instr_valid  output  1  instr/instr_pc hold a valid instruction
- instr_ready  input  1  decode accepts instruction this cycle
- instr  output  32  fetched instruction word
- instr_pc  output  32  address the instruction was fetched from
- redirect_valid  input  1  load new PC this cycle
- redirect_target  input  32  new PC for redirect
- fetch_count  output  32  number of instructions delivered (handshakes)
- misaligned_error  output  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (asynchronous, takes effect immediately) forces these values:
  - pc = RESET_PC, state = IDLE
  - instr_valid = 0, instr = 0, instr_pc = 0
  - fetch_count = 0, misaligned_error = 0
- Reset asserted mid-stall or mid-redirect discards everything; no partial state survives.
- imem_address = pc at all times. There is no memory-side handshake; the word is captured in the same cycle.
- Handshake: transfer occurs when instr_valid && instr_ready.
  - instr, instr_pc and instr_valid are stable while instr_valid && !instr_ready.
- A fetch happens on a rising edge when all of the following hold: enable=1, redirect_valid=0, and (instr_valid=0 or transfer).
  - On a fetch: instr <= imem_instruction, instr_pc <= pc, instr_valid <= 1, pc <= pc + 4.
  - pc + 4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - Effective latency: an address driven in cycle N appears on instr in cycle N+1.
  - Back-to-back fetches give 1 instruction per cycle while instr_ready=1.
- FSM states (2-bit encoding):
  - IDLE: instr_valid=0, no fetch in flight. Goes to RUN on a fetch edge; otherwise stays.
  - RUN: instr_valid=1, last cycle accepted or just fetched.
    - Transfer with a fetch: stay in RUN.
    - Transfer without a fetch (enable=0): go to IDLE, instr_valid <= 0.
    - No transfer: go to STALL.
  - STALL: instr_valid=1, waiting for instr_ready; pc frozen. On transfer, same rules as RUN.
- Redirect has highest priority (after reset):
  - pc <= {redirect_target[31:2], 2'b00}; instr_valid <= 0; state <= IDLE; no fetch this edge.
  - The next fetch (if enable=1) reads the target.
  - If redirect_target[1:0] != 0: misaligned_error <= 1. It is sticky and cleared only by reset. Fetching continues from the aligned address.
- Redirect and transfer in the same cycle: the transfer completes and is counted; the output is then invalidated.
- Redirect while stalled: the held instruction is discarded and not counted.
- fetch_count increments by 1 on every transfer and wraps modulo 2^32. Flushed or never-delivered instructions are not counted.
- enable=0 in STALL: hold until transfer, then go to IDLE. A deasserted enable never drops a valid instruction.
- Reserved FSM encoding: go to IDLE with instr_valid <= 0.

Test Plan:
- Bench memory returns 0xA000_0000 | address.
  - Stimulus: reset, enable=1, instr_ready=1.
  - Required: IDLE, then instr_valid=1 with instr=0xA000_0000/instr_pc=0, then 0xA000_0004/4, 0xA000_0008/8, one per cycle; fetch_count=3 after 3 transfers.
- Stall: hold instr_ready=0 for 3 cycles while instr_pc=8.
  - Required: instr=0xA000_0008 stable, imem_address=0xC, fetch_count unchanged.
  - Then instr_ready=1: the next instr_pc is 0xC.
- Redirect with target 0x40 while stalled on instr_pc=0x10.
  - Required: instr_valid=0 next cycle, the 0x10 instruction is never counted, the next instruction is 0xA000_0040/0x40, misaligned_error=0.
- Redirect with target 0x22, issued in the same cycle as a transfer.
  - Required: fetch_count increments by 1, pc=0x20, misaligned_error=1 and stays 1 until reset.
- Wrap: RESET_PC=32'hFFFF_FFFC.
  - Required: instr_pc sequence 0xFFFF_FFFC, 0x0000_0000.
- Assert reset asynchronously mid-STALL.
  - Required: instr_valid=0, pc=RESET_PC, fetch_count=0 immediately, before the next clock edge.
